// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset/lock sequencer: FSM state encoding,
// retry counter width and the helper that sizes the internal counter.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLLRST    = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } seq_state_e;

  localparam int RETRY_W = 8;

  // Smallest counter width that can hold the largest timing parameter
  // without wrapping.
  function automatic int calc_cnt_w(input int timeout, input int filter,
                                    input int gap, input int rst_cycles);
    int m;
    m = timeout;
    if (filter > m) m = filter;
    if (gap > m) m = gap;
    if (rst_cycles > m) m = rst_cycles;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous status inputs.
// Both stages clear to 0 on reset so a stale "good" level is never seen.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // Two back-to-back capture stages; only sync_reg is used downstream.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock manager: pulses the PLL reset, waits (with timeout and
// retry) for a filtered lock, then releases per-domain resets in order.
// Any lock loss after release drops every domain back into reset at once.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = 4,
  parameter int LOCK_FILTER    = 1024,
  parameter int STAGE_GAP      = 16,
  parameter int PLL_RST_CYCLES = 8,
  parameter int LOCK_TIMEOUT   = 1048576,
  parameter int CNT_W          = 21
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   pll_locked,
  input  logic                   force_reset,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   all_ready,
  output logic [RETRY_W-1:0]     retry_count,
  output logic [2:0]             seq_state
);

  // Elaboration-time parameter sanity checks.
  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 16) begin : g_bad_num_domains
    $error("NUM_DOMAINS must be in 1..16");
  end
  if (STAGE_GAP < 1 || PLL_RST_CYCLES < 1 || LOCK_FILTER < 1 || LOCK_TIMEOUT < 1) begin : g_bad_timing
    $error("STAGE_GAP, PLL_RST_CYCLES, LOCK_FILTER and LOCK_TIMEOUT must be >= 1");
  end
  if (CNT_W < calc_cnt_w(LOCK_TIMEOUT, LOCK_FILTER, STAGE_GAP, PLL_RST_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too small for the timing parameters");
  end

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  seq_state_e               state_reg, state_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic                     pll_rst_reg, pll_rst_next;
  logic [NUM_DOMAINS-1:0]   domain_rst_reg, domain_rst_next;
  logic [NUM_DOMAINS-1:0]   domain_shift;
  logic                     all_ready_reg, all_ready_next;
  logic [RETRY_W-1:0]       retry_reg, retry_next;
  logic                     lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      (pll_locked),
    .q      (lock_s)
  );

  // Releasing one more domain = shifting a zero in from bit 0, so resets can
  // only ever come off in ascending order.
  assign domain_shift = domain_rst_reg << 1;

  // State, counter and all outputs are registered here.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg      <= PLLRST;
      cnt_reg        <= '0;
      pll_rst_reg    <= 1'b1;
      domain_rst_reg <= '1;
      all_ready_reg  <= 1'b0;
      retry_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      pll_rst_reg    <= pll_rst_next;
      domain_rst_reg <= domain_rst_next;
      all_ready_reg  <= all_ready_next;
      retry_reg      <= retry_next;
    end
  end

  // Next-state and next-output logic; force_reset overrides everything else.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    pll_rst_next    = pll_rst_reg;
    domain_rst_next = domain_rst_reg;
    all_ready_next  = all_ready_reg;
    retry_next      = retry_reg;

    if (force_reset) begin
      state_next      = PLLRST;
      cnt_next        = '0;
      pll_rst_next    = 1'b1;
      domain_rst_next = '1;
      all_ready_next  = 1'b0;
    end else begin
      case (state_reg)
        PLLRST: begin
          if (cnt_reg == RST_LAST) begin
            state_next   = WAIT_LOCK;
            cnt_next     = '0;
            pll_rst_next = 1'b0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end

        WAIT_LOCK: begin
          if (lock_s) begin
            // This cycle already counts as the first good lock cycle.
            state_next = FILTER;
            cnt_next   = CNT_ONE;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            state_next   = PLLRST;
            cnt_next     = '0;
            pll_rst_next = 1'b1;
            if (retry_reg != '1) begin
              retry_next = retry_reg + RETRY_W'(1);
            end
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end

        FILTER: begin
          if (!lock_s) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_reg >= FILTER_LAST) begin
            cnt_next        = '0;
            domain_rst_next = domain_shift;
            if (domain_shift == '0) begin
              state_next     = RUN;
              all_ready_next = 1'b1;
            end else begin
              state_next = RELEASE;
            end
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end

        RELEASE, RUN: begin
          if (!lock_s) begin
            // The PLL re-locks on its own; no new PLL reset pulse.
            state_next      = WAIT_LOCK;
            cnt_next        = '0;
            domain_rst_next = '1;
            all_ready_next  = 1'b0;
          end else if (state_reg == RELEASE) begin
            if (cnt_reg == GAP_LAST) begin
              cnt_next        = '0;
              domain_rst_next = domain_shift;
              if (domain_shift == '0) begin
                state_next     = RUN;
                all_ready_next = 1'b1;
              end
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
        end

        default: begin
          state_next      = PLLRST;
          cnt_next        = '0;
          pll_rst_next    = 1'b1;
          domain_rst_next = '1;
          all_ready_next  = 1'b0;
        end
      endcase
    end
  end

  assign pll_rst     = pll_rst_reg;
  assign domain_rst  = domain_rst_reg;
  assign all_ready   = all_ready_reg;
  assign retry_count = retry_reg;
  assign seq_state   = state_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios plus a
// random lock/force phase, all checked every cycle against a timestamp model.
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  localparam int ND  = 3;
  localparam int LF  = 8;
  localparam int SG  = 4;
  localparam int PRC = 3;
  localparam int LT  = 32;
  localparam int CW  = calc_cnt_w(LT, LF, SG, PRC);

  logic          clk = 1'b0;
  logic          resetn;
  logic          pll_locked;
  logic          force_reset;
  logic          pll_rst;
  logic [ND-1:0] domain_rst;
  logic          all_ready;
  logic [7:0]    retry_count;
  logic [2:0]    seq_state;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .NUM_DOMAINS    (ND),
    .LOCK_FILTER    (LF),
    .STAGE_GAP      (SG),
    .PLL_RST_CYCLES (PRC),
    .LOCK_TIMEOUT   (LT),
    .CNT_W          (CW)
  ) dut (
    .clock       (clk),
    .resetn      (resetn),
    .pll_locked  (pll_locked),
    .force_reset (force_reset),
    .pll_rst     (pll_rst),
    .domain_rst  (domain_rst),
    .all_ready   (all_ready),
    .retry_count (retry_count),
    .seq_state   (seq_state)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: described by elapsed times rather than by a state register.
  int now = 0;         // edge counter
  bit pulsing;         // PLL reset pulse in progress
  int pulse_left;      // edges left in the pulse
  int wait_el;         // cycles spent waiting without lock
  int good_run;        // consecutive lock_s-high cycles seen
  int rel_t;           // edge at which domain 0 was released, -1 if none
  int retries;
  bit s1, s2;          // raw lock history (synchroniser delay)

  task automatic check_val(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_ready();
    return (rel_t >= 0 && now - rel_t >= SG * (ND - 1)) ? 1 : 0;
  endfunction

  function automatic int exp_dom();
    int v = 0;
    for (int i = 0; i < ND; i++)
      if (!(rel_t >= 0 && now - rel_t >= SG * i)) v |= (1 << i);
    return v;
  endfunction

  function automatic int exp_seq();
    if (pulsing) return 0;
    if (rel_t < 0) return (good_run > 0) ? 2 : 1;
    return (exp_ready() == 1) ? 4 : 3;
  endfunction

  task automatic model_step();
    bit ls;
    now++;
    if (!resetn) begin
      pulsing = 1; pulse_left = PRC; wait_el = 0; good_run = 0;
      rel_t = -1; retries = 0; s1 = 0; s2 = 0;
    end else begin
      ls = s2; s2 = s1; s1 = pll_locked;
      if (force_reset) begin
        pulsing = 1; pulse_left = PRC; good_run = 0; rel_t = -1;
      end else if (pulsing) begin
        pulse_left--;
        if (pulse_left == 0) begin
          pulsing = 0; wait_el = 0; good_run = 0;
        end
      end else if (rel_t >= 0) begin
        if (!ls) begin
          rel_t = -1; wait_el = 0; good_run = 0;
        end
      end else if (ls) begin
        good_run++;
        if (good_run >= LF) begin
          rel_t = now; good_run = 0;
        end
      end else if (good_run > 0) begin
        good_run = 0; wait_el = 0;
      end else if (wait_el == LT - 1) begin
        pulsing = 1; pulse_left = PRC;
        if (retries < 255) retries++;
      end else begin
        wait_el++;
      end
    end
  endtask

  task automatic check_all();
    check_val("pll_rst", int'(pll_rst), int'(pulsing));
    check_val("domain_rst", int'(domain_rst), exp_dom());
    check_val("all_ready", int'(all_ready), exp_ready());
    check_val("retry_count", int'(retry_count), retries);
    check_val("seq_state", int'(seq_state), exp_seq());
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until_run(input string tag, input int budget);
    int k = 0;
    while (exp_seq() != 4 && k < budget) begin
      step();
      k++;
    end
    check_val(tag, int'(seq_state), 4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    resetn = 1'b0; pll_locked = 1'b1; force_reset = 1'b0;

    // 1: reset state, then release with lock held high
    repeat (3) step();
    check_val("rst_pll_rst", int'(pll_rst), 1);
    check_val("rst_domain", int'(domain_rst), 7);
    check_val("rst_ready", int'(all_ready), 0);
    check_val("rst_retry", int'(retry_count), 0);
    check_val("rst_state", int'(seq_state), 0);
    $display("[TB] reset held: pll_rst=%0d domain_rst=%b state=%0d", pll_rst, domain_rst, seq_state);
    resetn = 1'b1;
    n = 0;
    do begin step(); n++; end while (pll_rst == 1'b1 && n < 20);
    check_val("s1_pll_rst_width", n, PRC);
    k = 0;
    while (domain_rst[0] == 1'b1 && k < 50) begin step(); k++; end
    n = 0;
    while (domain_rst[1] == 1'b1 && n < 50) begin step(); n++; end
    check_val("s1_gap_bit1", n, SG);
    n = 0;
    while (domain_rst[2] == 1'b1 && n < 50) begin step(); n++; end
    check_val("s1_gap_bit2", n, SG);
    check_val("s1_all_ready", int'(all_ready), 1);
    check_val("s1_state_run", int'(seq_state), 4);
    $display("[TB] scenario 1 staged release: gaps checked, all_ready=%0d", all_ready);

    // 4: lock loss in RUN
    pll_locked = 1'b0;
    n = 0;
    do begin step(); n++; end while (all_ready == 1'b1 && n < 10);
    check_val("s4_loss_latency", n, 3);
    check_val("s4_domain_all", int'(domain_rst), 7);
    check_val("s4_pll_rst_low", int'(pll_rst), 0);
    pll_locked = 1'b1;
    run_until_run("s4_rerun", 100);
    $display("[TB] scenario 4 lock loss in RUN: latency %0d, re-released", n);

    // 2a: two timeouts with lock held low
    pll_locked = 1'b0;
    k = 0;
    while (retries < 2 && k < 200) begin step(); k++; end
    check_val("s2a_retry", int'(retry_count), 2);
    $display("[TB] two lock timeouts: retry_count=%0d", retry_count);

    // 3: one-cycle lock glitch during FILTER
    pll_locked = 1'b1;
    k = 0;
    while (good_run != 5 && k < 100) begin step(); k++; end
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    n = 0;
    do begin step(); n++; end while (domain_rst[0] == 1'b1 && n < 40);
    check_val("s3_release_delay", n, 2 + LF);
    run_until_run("s3_run", 100);
    $display("[TB] scenario 3 lock glitch: release %0d cycles after re-lock", n);

    // 5: force_reset mid-RELEASE coincident with lock loss
    pll_locked = 1'b0;
    repeat (3) step();
    pll_locked = 1'b1;
    k = 0;
    while (exp_dom() != 6 && k < 60) begin step(); k++; end
    check_val("s5_mid_release", int'(domain_rst), 6);
    pll_locked = 1'b0;
    step();
    step();
    force_reset = 1'b1;
    step();
    force_reset = 1'b0;
    pll_locked = 1'b1;
    check_val("s5_state", int'(seq_state), 0);
    check_val("s5_domain", int'(domain_rst), 7);
    check_val("s5_pll_rst", int'(pll_rst), 1);
    check_val("s5_retry_kept", int'(retry_count), 2);
    n = 0;
    while (pll_rst == 1'b1 && n < 20) begin step(); n++; end
    check_val("s5_pll_rst_width", n, PRC);
    run_until_run("s5_run", 100);
    $display("[TB] scenario 5 force during release: pulse edges %0d", n);

    // 6: resetn low for one cycle during RUN
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check_val("s6_pll_rst", int'(pll_rst), 1);
    check_val("s6_domain", int'(domain_rst), 7);
    check_val("s6_ready", int'(all_ready), 0);
    check_val("s6_retry", int'(retry_count), 0);
    check_val("s6_state", int'(seq_state), 0);
    run_until_run("s6_run", 100);
    $display("[TB] scenario 6 reset in RUN: sequence restarted");

    // 2b: lock never arrives; pulse spacing and saturation
    pll_locked = 1'b0;
    k = 0;
    while (pll_rst == 1'b0 && k < 100) begin step(); k++; end
    k = 0;
    while (pll_rst == 1'b1 && k < 20) begin step(); k++; end
    n = 0;
    while (pll_rst == 1'b0 && n < 100) begin step(); n++; end
    check_val("s2_wait_len", n, LT);
    k = 0;
    while (retries < 255 && k < 255 * 40) begin step(); k++; end
    repeat (80) step();
    check_val("s2_retry_sat", int'(retry_count), 255);
    $display("[TB] scenario 2 timeouts: wait=%0d retry_count=%0d", n, retry_count);

    // random lock activity, occasional force/reset
    for (int seg = 0; seg < 150; seg++) begin
      pll_locked = 1'($urandom_range(0, 1));
      for (int c = 0; c < int'($urandom_range(1, 40)); c++) begin
        force_reset = ($urandom_range(0, 99) == 0);
        resetn = ($urandom_range(0, 499) != 0);
        step();
      end
    end
    force_reset = 1'b0;
    resetn = 1'b1;
    $display("[TB] random phase done at edge %0d", now);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
